// File: rtl/sev_seg_bcd_converter.sv
// rtl/sev_seg_bcd_converter.sv - binary to packed BCD converter (serial double-dabble) for seven-segment display
module sev_seg_bcd_converter #(
  parameter int IN_WIDTH = 24,
  parameter int DIGITS   = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_stall,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_stall,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_overflow,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  // Largest value representable in DIGITS decimal digits, built with shift-adds only.
  function automatic logic [63:0] f_max_value(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = (v << 3) + (v << 1);
    end
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VALUE = f_max_value(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [IN_WIDTH-1:0]  r_shift;
  logic [BCD_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic [BCD_W-1:0]     r_out_bcd;
  logic                 r_out_ovf;

  logic [BCD_W-1:0]     w_adj;
  logic [BCD_W-1:0]     w_next_acc;
  logic [IN_WIDTH-1:0]  w_next_shift;
  logic                 w_unused_msb;
  logic                 w_accept;
  logic                 w_last_step;
  logic                 w_in_over;

  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_last_step = (r_state == S_CONVERT) && (r_cnt == CNT_W'(1));
  assign w_in_over   = {{(64-IN_WIDTH){1'b0}}, in_data} > MAX_VALUE;

  // Add-3 correction on every accumulator digit that would carry incorrectly after the shift.
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // One-bit left shift of {accumulator, shift register}; the bit leaving the top digit is dropped.
  assign {w_unused_msb, w_next_acc, w_next_shift} = {w_adj, r_shift, 1'b0};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    w_next_state = r_state;
    in_stall     = 1'b1;
    busy         = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_stall = 1'b0;
        if (in_valid) begin
          w_next_state = S_CONVERT;
        end
      end
      S_CONVERT: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (!out_stall) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Conversion datapath: load on accept, one double-dabble step per CONVERT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_shift <= in_data;
      r_acc   <= '0;
      r_cnt   <= CNT_W'(IN_WIDTH);
      r_ovf   <= w_in_over;
    end else if (r_state == S_CONVERT) begin
      r_shift <= w_next_shift;
      r_acc   <= w_next_acc;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // Result registers update only on DONE entry so the display stays static otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_bcd <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_last_step) begin
      r_out_bcd <= r_ovf ? {DIGITS{4'h9}} : w_next_acc;
      r_out_ovf <= r_ovf;
    end
  end

  assign out_bcd      = r_out_bcd;
  assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_sev_seg_bcd_converter.sv
// tb/tb_sev_seg_bcd_converter.sv - self-checking bench for sev_seg_bcd_converter
module tb_sev_seg_bcd_converter;

  localparam int IN_WIDTH = 24;
  localparam int DIGITS   = 6;
  localparam int BCD_W    = 4 * DIGITS;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_stall;
  logic [IN_WIDTH-1:0]  in_data = '0;
  logic                 out_valid;
  logic                 out_stall = 1'b0;
  logic [BCD_W-1:0]     out_bcd;
  logic                 out_overflow;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  sev_seg_bcd_converter #(
    .IN_WIDTH (IN_WIDTH),
    .DIGITS   (DIGITS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_stall     (in_stall),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_stall    (out_stall),
    .out_bcd      (out_bcd),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal conversion from plain arithmetic; saturates to all nines above the digit range.
  function automatic void ref_conv(input longint unsigned v, output logic [BCD_W-1:0] bcd,
                                   output logic ovf);
    longint unsigned lim;
    longint unsigned x;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    bcd = '0;
    if (v >= lim) begin
      ovf = 1'b1;
      for (int i = 0; i < DIGITS; i++) bcd[4*i +: 4] = 4'd9;
    end else begin
      ovf = 1'b0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
        bcd[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
  endfunction

  // Transaction-level model: 0 idle, 1 converting, 2 result presented.
  int                m_phase = 0;
  int                m_left = 0;
  longint unsigned   q_sent[$];
  logic [BCD_W-1:0]  m_bcd = '0;
  logic              m_ovf = 1'b0;
  int                n_xfer = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0;
      m_left  = 0;
      m_bcd   = '0;
      m_ovf   = 1'b0;
      q_sent.delete();
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          q_sent.push_back(64'(in_data));
          m_left  = IN_WIDTH;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            ref_conv(q_sent.pop_front(), m_bcd, m_ovf);
            m_phase = 2;
          end
        end
        default: if (!out_stall) begin
          m_phase = 0;
          n_xfer++;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model, sampled after the edge settles.
  always @(posedge clk) begin
    logic [63:0] act;
    logic [63:0] exp;
    #3;
    act = 64'({out_valid, busy, in_stall, out_overflow, out_bcd});
    exp = 64'({(m_phase == 2), (m_phase == 1), (m_phase != 0), m_ovf, m_bcd});
    chk("cycle", act, exp);
  end

  // Present a value (caller sits at a negedge); returns at the negedge after the accepting edge.
  task automatic accept(input logic [IN_WIDTH-1:0] v);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (in_stall && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("accept_timeout", 64'(t), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [BCD_W-1:0] eb, input logic eo);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 100);
    chk({name, "_latency"}, 64'(k), 64'(IN_WIDTH));
    chk({name, "_bcd"}, 64'(out_bcd), 64'(eb));
    chk({name, "_ovf"}, 64'(out_overflow), 64'(eo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t required below 1000000", $time);
    $fatal(1);
  end

  initial begin
    logic [BCD_W-1:0] pb;
    logic             po;
    int               sent;
    int               iter;
    int               base;

    ref_conv(64'd987654, pb, po);
    chk("model_987654_bcd", 64'(pb), 64'h987654);
    ref_conv(64'd1000000, pb, po);
    chk("model_1e6_ovf", 64'(po), 64'd1);

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({out_valid, busy, in_stall, out_overflow, out_bcd}), 64'd0);
    reset_n = 1'b1;

    accept(24'd0);
    wait_result("zero", 24'h000000, 1'b0);
    accept(24'd123456);
    wait_result("d123456", 24'h123456, 1'b0);
    accept(24'd999999);
    wait_result("d999999", 24'h999999, 1'b0);
    accept(24'd1000000);
    wait_result("d1000000", 24'h999999, 1'b1);
    accept(24'hFFFFFF);
    wait_result("dmax", 24'h999999, 1'b1);
    accept(24'd42);
    wait_result("d42", 24'h000042, 1'b0);

    accept(24'd314159);
    wait_result("stall_pre", 24'h314159, 1'b0);
    out_stall = 1'b1;
    in_valid  = 1'b1;
    in_data   = 24'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", 64'({out_valid, in_stall, out_overflow, out_bcd}),
          64'({1'b1, 1'b1, 1'b0, 24'h314159}));
    end
    out_stall = 1'b0;
    @(negedge clk);
    chk("stall_release", 64'({out_valid, in_stall, out_bcd}), 64'({1'b0, 1'b0, 24'h314159}));
    accept(24'd7);
    wait_result("d7", 24'h000007, 1'b0);

    accept(24'd555555);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_reset", 64'({out_valid, busy, in_stall, out_overflow, out_bcd}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    accept(24'd654321);
    wait_result("after_reset", 24'h654321, 1'b0);

    @(negedge clk);
    base     = n_xfer;
    sent     = 1;
    iter     = 0;
    in_valid = 1'b1;
    in_data  = IN_WIDTH'($urandom_range(0, 999999));
    while (iter < 20000) begin
      @(negedge clk);
      iter++;
      out_stall = ($urandom_range(0, 3) == 0);
      if (!in_stall) begin
        if (sent < 100) begin
          in_data = IN_WIDTH'($urandom_range(0, 999999));
          sent++;
        end else begin
          in_valid = 1'b0;
          break;
        end
      end
    end
    out_stall = 1'b0;
    iter = 0;
    while ((n_xfer - base) < 100 && iter < 2000) begin
      @(negedge clk);
      iter++;
    end
    chk("random_transfers", 64'(n_xfer - base), 64'd100);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
